parity_sorter: RTL
==================

Name: parity_sorter

Overview:
- Downstream consumer of the div2 parity stage.
- Accepts a data word together with its even flag (div2 `ans`) over a valid/ready handshake.
- Steers each word into one of two FIFOs, an even queue and an odd queue, each drained through its own valid/ready output port.
- Keeps saturating per-class word counters for status and debug.

Parameters:
- IN_WIDTH, 16, width of data words (matches div2 IN_WIDTH).
- DEPTH, 4, entries per FIFO; must be a power of two and at least 2.
- CNT_WIDTH, 8, width of each saturating class counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  upstream word present.
- in_ready  output  1  block can accept a word this cycle.
- in_data  input  IN_WIDTH  word to classify.
- in_even  input  1  even flag from div2 `ans`; 1 = even, 0 = odd.
- even_valid  output  1  even FIFO head valid.
- even_ready  input  1  downstream pops the even head.
- even_data  output  IN_WIDTH  even FIFO head word.
- odd_valid  output  1  odd FIFO head valid.
- odd_ready  input  1  downstream pops the odd head.
- odd_data  output  IN_WIDTH  odd FIFO head word.
- even_cnt  output  CNT_WIDTH  accepted even words, saturating.
- odd_cnt  output  CNT_WIDTH  accepted odd words, saturating.

Behaviour:
- Reset (rst_n=0 at a clk edge): both FIFOs empty (pointers and occupancy 0); even_valid=0, odd_valid=0; even_cnt=0, odd_cnt=0.
- During reset, even_data and odd_data are 0.
- in_ready is 0 while rst_n=0.
- Reset asserted mid-operation discards all queued words; handshakes in that cycle have no effect.
- in_ready = rst_n && !even_full && !odd_full.
  - in_ready is registered-state based only.
  - It has no combinational dependence on in_valid, in_even or in_data.
- Accept: in_valid && in_ready at a clk edge.
  - Word goes to the even FIFO if in_even=1, else to the odd FIFO.
  - The matching counter increments by 1, holding at 2^CNT_WIDTH-1 once reached (no wrap).
- in_data/in_even must be held stable while in_valid=1 and in_ready=0.
  - The bench checks this; the block does not.
- Outputs are first-word-fall-through: x_valid = !x_empty, and x_data = the entry at the read pointer.
- x_data is 0 when the FIFO is empty.
- Latency: a word accepted at edge N is visible on its output at the start of the cycle after edge N (1 cycle). There is no bypass path.
- Pop: x_valid && x_ready at a clk edge advances that read pointer. x_ready while x_valid=0 is ignored.
- Simultaneous push and pop on the same FIFO:
  - Both happen; occupancy is unchanged.
  - Allowed whenever that FIFO is neither full (push blocked by in_ready) nor empty (nothing to pop).
- Push into one FIFO plus pop from the other in the same cycle: both happen independently.
- Full: a FIFO is full when occupancy = DEPTH. Either FIFO full forces in_ready=0, even if the incoming word targets the other FIFO (head-of-line blocking by design).
- A pop from a full FIFO at edge N reopens in_ready in the cycle after edge N.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Occupancy is log2(DEPTH)+1 bits, range 0..DEPTH.
- Order is preserved within each class. There is no ordering guarantee between classes.
- Counters count accepts, not pops. They are never decremented.

Test Plan:
1. Reset then stream 65535, 12348, 64, 32, 15, 6, 0 (even flags 0,1,1,1,0,1,1), with even_ready=odd_ready=1 -> even port emits 12348, 64, 32, 6, 0; odd port emits 65535, 15; each word appears one cycle after its accept; even_cnt=5, odd_cnt=2.
2. even_ready=0; push 2, 4, 6, 8 -> even FIFO full, in_ready=0 even while presenting odd word 7; raise even_ready for one cycle -> 2 popped, in_ready=1 next cycle, 7 accepted into odd FIFO.
3. DEPTH=4, hold the even FIFO at occupancy 2 and push plus pop every cycle for 10 cycles -> occupancy stays 2; output order matches input order across pointer wrap.
4. CNT_WIDTH=3; accept 9 odd words with odd_ready=1 -> odd_cnt reads 7 after the 7th accept and stays 7; even_cnt=0.
5. Queue 3 even and 2 odd words, then drive rst_n=0 for one cycle with in_valid=1 -> after the reset edge all valids are 0, counters are 0, and the reset-cycle word is not stored; in_ready returns to 1 in the cycle after rst_n rises.
6. Idle FIFOs: assert even_ready=odd_ready=1 with no input -> no valids, no counter change, and data outputs stay 0.

Source files
------------

// File: rtl/parity_sorter.sv
// Splits an incoming word stream into even and odd first-word-fall-through
// FIFOs, keeping a saturating count of accepted words per class.
module parity_sorter #(
   parameter int IN_WIDTH  = 16,
   parameter int DEPTH     = 4,
   parameter int CNT_WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [IN_WIDTH-1:0]  in_data,
   input  logic                 in_even,
   output logic                 even_valid,
   input  logic                 even_ready,
   output logic [IN_WIDTH-1:0]  even_data,
   output logic                 odd_valid,
   input  logic                 odd_ready,
   output logic [IN_WIDTH-1:0]  odd_data,
   output logic [CNT_WIDTH-1:0] even_cnt,
   output logic [CNT_WIDTH-1:0] odd_cnt
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int OW = PW + 1;
   localparam logic [OW-1:0] OCC_FULL = OW'(DEPTH);

   // Per-class vectors: index 0 is the even queue, index 1 the odd queue.
   logic [1:0]          full;
   logic [1:0]          empty;
   logic [1:0]          valid;
   logic [1:0]          ready;
   logic [1:0]          push;
   logic [1:0]          pop;
   logic [IN_WIDTH-1:0] head [2];
   logic [CNT_WIDTH-1:0] cnt [2];
   logic                accept;

   assign ready    = {odd_ready, even_ready};
   // Either queue full stalls the input, regardless of which class is waiting.
   assign in_ready = rst_n && (full == 2'b00);
   assign accept   = in_valid && in_ready;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_fifo
         localparam logic EVEN_CLASS = (gi == 0);

         logic [IN_WIDTH-1:0]  mem [DEPTH];
         logic [PW-1:0]        wr_ptr_reg;
         logic [PW-1:0]        rd_ptr_reg;
         logic [OW-1:0]        occ_reg;
         logic [CNT_WIDTH-1:0] cnt_reg;

         assign push[gi]  = accept && (in_even == EVEN_CLASS);
         assign empty[gi] = (occ_reg == '0);
         assign full[gi]  = (occ_reg == OCC_FULL);
         assign valid[gi] = !empty[gi];
         assign pop[gi]   = valid[gi] && ready[gi];
         assign head[gi]  = (rst_n && !empty[gi]) ? mem[rd_ptr_reg] : '0;
         assign cnt[gi]   = cnt_reg;

         // Storage carries no reset; occupancy alone decides what is live.
         always_ff @(posedge clk) begin
            if (push[gi]) begin
               mem[wr_ptr_reg] <= in_data;
            end
         end

         always_ff @(posedge clk) begin
            if (!rst_n) begin
               wr_ptr_reg <= '0;
               rd_ptr_reg <= '0;
               occ_reg    <= '0;
               cnt_reg    <= '0;
            end else begin
               if (push[gi]) begin
                  wr_ptr_reg <= wr_ptr_reg + PW'(1);
               end
               if (pop[gi]) begin
                  rd_ptr_reg <= rd_ptr_reg + PW'(1);
               end
               case ({push[gi], pop[gi]})
                  2'b10:   occ_reg <= occ_reg + OW'(1);
                  2'b01:   occ_reg <= occ_reg - OW'(1);
                  default: occ_reg <= occ_reg;
               endcase
               if (push[gi] && (cnt_reg != '1)) begin
                  cnt_reg <= cnt_reg + CNT_WIDTH'(1);
               end
            end
         end
      end
   endgenerate

   assign even_valid = valid[0];
   assign even_data  = head[0];
   assign even_cnt   = cnt[0];
   assign odd_valid  = valid[1];
   assign odd_data   = head[1];
   assign odd_cnt    = cnt[1];

endmodule
